// File: rtl/sm_add_pkg.sv
// Shared definitions for the sign-magnitude add/subtract sequencer.
//   DefaultW : default magnitude width (operands are DefaultW+1 bits {sign, mag})
//   state_e  : sequencer state encoding
package sm_add_pkg;

  localparam int unsigned DefaultW = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StNeg  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/sm_add_ctrl.sv
// Multi-cycle sequencer for sign-magnitude add/subtract around a shared W-bit magnitude adder
// (add_a + add_b + add_cin -> W+1-bit add_sum). The adder sits outside this block.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start, op_sub     : request (sampled only when idle), 0 = a+b, 1 = a-b
//   a, b              : sign-magnitude operands {sign, mag[W-1:0]}
//   busy, done        : busy in every non-idle state, done is a one-cycle result-valid pulse
//   result, overflow  : sign-magnitude result and effective-add carry-out, held between ops
//   add_a/add_b/add_cin, add_sum : drive to / sum from the external magnitude adder
module sm_add_ctrl
  import sm_add_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W:0]   a,
  input  logic [W:0]   b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result,
  output logic         overflow,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W:0]   add_sum
);

  state_e       state_q;
  logic         sa_q;
  logic [W-1:0] ma_q;
  logic [W-1:0] mb_q;
  logic         eff_sub_q;
  logic [W-1:0] diff_q;
  logic [W:0]   result_q;
  logic         overflow_q;
  logic         busy_q;
  logic         done_q;

  logic [W-1:0] sum_mag;
  logic         sum_carry;

  assign sum_mag   = add_sum[W-1:0];
  assign sum_carry = add_sum[W];

  // Adder drive depends only on the current state; zero whenever the adder is not in use.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      StExec: begin
        add_a   = ma_q;
        add_b   = eff_sub_q ? ~mb_q : mb_q;
        add_cin = eff_sub_q;
      end
      StNeg: begin
        // Two's-complement negate of the borrowed difference: ~diff + 1.
        add_a   = ~diff_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sa_q       <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      eff_sub_q  <= 1'b0;
      diff_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q      <= a[W];
            ma_q      <= a[W-1:0];
            mb_q      <= b[W-1:0];
            eff_sub_q <= a[W] ^ b[W] ^ op_sub;
            busy_q    <= 1'b1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          if (!eff_sub_q || sum_carry) begin
            // Effective add, or subtract with ma >= mb: result keeps the sign of A.
            // A zero magnitude never carries a negative sign.
            result_q   <= {sa_q & (|sum_mag), sum_mag};
            overflow_q <= ~eff_sub_q & sum_carry;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            // No carry-out means ma < mb: the difference must be negated.
            diff_q  <= sum_mag;
            state_q <= StNeg;
          end
        end
        StNeg: begin
          result_q   <= {~sa_q & (|sum_mag), sum_mag};
          overflow_q <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sm_add_ctrl.sv
// Testbench for sm_add_ctrl with a behavioural W=7 magnitude adder wired beside it.
module tb_sm_add_ctrl;

  localparam int unsigned W = 7;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [W:0]   a;
  logic [W:0]   b;
  logic         busy;
  logic         done;
  logic [W:0]   result;
  logic         overflow;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W:0]   add_sum;

  int tests = 0;
  int fails = 0;

  sm_add_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum)
  );

  // Real adder: a + b + cin, W+1-bit sum.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and wait for done; lat counts edges from the accepting edge (0 = timed out).
  task automatic run_op(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                        output int lat, output logic [7:0] r, output logic o);
    @(negedge clk);
    op_sub = s;
    a      = ia;
    b      = ib;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    r   = 8'h00;
    o   = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        r   = result;
        o   = overflow;
        break;
      end
    end
  endtask

  int         lat;
  logic [7:0] r;
  logic       o;
  int         ndone;

  initial begin
    vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 2};
    vecs[1] = '{1'b1, 8'h05, 8'h09, 8'h84, 1'b0, 3};
    vecs[2] = '{1'b0, 8'h94, 8'h14, 8'h00, 1'b0, 2};
    vecs[3] = '{1'b0, 8'h64, 8'h32, 8'h16, 1'b1, 2};
    vecs[4] = '{1'b1, 8'h83, 8'h87, 8'h04, 1'b0, 3};
    vecs[5] = '{1'b0, 8'hC0, 8'hC0, 8'h00, 1'b1, 2};  // -64 + -64 wraps to zero, sign cleared
    vecs[6] = '{1'b1, 8'h7F, 8'hFF, 8'h7E, 1'b1, 2};  // 127 - (-127)
    vecs[7] = '{1'b1, 8'h00, 8'h01, 8'h81, 1'b0, 3};  // 0 - 1
    vecs[8] = '{1'b0, 8'h8A, 8'h05, 8'h85, 1'b0, 2};  // -10 + 5
    vecs[9] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b0, 2};  // -0 + 0

    rst    = 1'b1;
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 8'h25;
    b      = 8'h13;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_adder", {16'd0, add_a, add_b, add_cin}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op_sub, vecs[i].a, vecs[i].b, lat, r, o);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), {24'd0, r}, {24'd0, vecs[i].res});
      check($sformatf("v%0d_overflow", i), {31'd0, o}, {31'd0, vecs[i].ov});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_width", i), {30'd0, done, busy}, 32'd0);
    end
    check("idle_adder", {16'd0, add_a, add_b, add_cin}, 32'd0);

    // Start pulsed while busy with changed operands: ignored, exactly one done, result of first op.
    @(negedge clk);
    op_sub = 1'b1;
    a      = 8'h83;
    b      = 8'h87;
    start  = 1'b1;
    @(posedge clk);
    #1;
    op_sub = 1'b0;
    a      = 8'h05;
    b      = 8'h03;
    ndone  = 0;
    r      = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) start = 1'b0;
      if (done) begin
        ndone++;
        r = result;
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_result", {24'd0, r}, 32'h04);

    // Start raised during DONE is ignored there and accepted in the following IDLE cycle.
    run_op(1'b0, 8'h8A, 8'h05, lat, r, o);
    check("pre_done_result", {24'd0, r}, 32'h85);
    op_sub = 1'b0;
    a      = 8'h05;
    b      = 8'h03;
    start  = 1'b1;
    @(posedge clk);
    #1;
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("idle_start_accepted", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("done_start_done", {31'd0, done}, 32'd1);
    check("done_start_result", {24'd0, result}, 32'h08);

    // Reset while in NEG aborts the op and clears the result.
    @(posedge clk);
    @(negedge clk);
    op_sub = 1'b1;
    a      = 8'h05;
    b      = 8'h09;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("neg_state_adder_cin", {31'd0, add_cin}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(1'b1, 8'h05, 8'h09, lat, r, o);
    check("post_reset_latency", lat, 3);
    check("post_reset_result", {24'd0, r}, 32'h84);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
